// File: rtl/dm_resp_if.sv
// Load/store request and response bundle between the CPU data port and dm_resp.
interface dm_resp_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  ls;
    logic        ready;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, we, addr, wdata, ls, input ready, rdata, err);
    modport slave  (input req, we, addr, wdata, ls, output ready, rdata, err);
endinterface

// File: rtl/dm_resp.sv
// Multi-cycle data-memory responder: one load/store at a time from a word RAM
// after WAIT wait states, with byte/half lanes, load extension and error flag.
module dm_resp #(
    parameter int AW   = 10,
    parameter int WAIT = 1
) (
    input  logic     clk,
    input  logic     rstn,
    dm_resp_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for req; latches the request on acceptance
    // WAIT  | counting wait states down to 1
    // RESP  | one-cycle ready strobe, then back to IDLE
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [2:0]  lat_ls;
    logic [31:0] mem [2**AW];

    logic        op_we;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [2:0]  op_ls;
    logic        commit;
    logic        fault;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] ld;
    logic [31:0] word;
    logic [7:0]  lane8;
    logic [15:0] lane16;
    logic        unused_ls3;

    assign unused_ls3 = bus.ls[3];

    // With WAIT=0 the access completes on the accepting edge, so the datapath
    // must see the live request in IDLE rather than the latched copy.
    assign op_we    = (state == S_IDLE) ? bus.we        : lat_we;
    assign op_addr  = (state == S_IDLE) ? bus.addr      : lat_addr;
    assign op_wdata = (state == S_IDLE) ? bus.wdata     : lat_wdata;
    assign op_ls    = (state == S_IDLE) ? bus.ls[2:0]   : lat_ls;

    assign commit = ((state == S_IDLE) && bus.req && (WAIT_CNT == 4'd0)) ||
                    ((state == S_WAIT) && (cnt == 4'd1));

    always_comb begin
        word   = mem[op_addr[AW+1:2]];
        lane8  = 8'(word >> {op_addr[1:0], 3'b000});
        lane16 = op_addr[1] ? word[31:16] : word[15:0];
        fault  = (op_ls[1:0] == 2'b11) ||
                 ((op_ls[1:0] == 2'b01) && op_addr[0]) ||
                 ((op_ls[1:0] == 2'b10) && (op_addr[1:0] != 2'b00)) ||
                 (op_addr[31:AW+2] != '0);
        be = 4'b0000;
        wd = '0;
        ld = '0;
        case (op_ls[1:0])
            2'b00: begin
                be = 4'b0001 << op_addr[1:0];
                wd = {4{op_wdata[7:0]}};
                ld = op_ls[2] ? {24'b0, lane8} : {{24{lane8[7]}}, lane8};
            end
            2'b01: begin
                be = op_addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{op_wdata[15:0]}};
                ld = op_ls[2] ? {16'b0, lane16} : {{16{lane16[15]}}, lane16};
            end
            2'b10: begin
                be = 4'b1111;
                wd = op_wdata;
                ld = word;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_ls    <= '0;
            bus.ready <= 1'b0;
            bus.err   <= 1'b0;
            bus.rdata <= '0;
        end else begin
            bus.ready <= commit;
            if (commit) begin
                bus.err   <= fault;
                bus.rdata <= (fault || op_we) ? 32'd0 : ld;
            end
            case (state)
                S_IDLE: if (bus.req) begin
                    lat_we    <= bus.we;
                    lat_addr  <= bus.addr;
                    lat_wdata <= bus.wdata;
                    lat_ls    <= bus.ls[2:0];
                    cnt       <= WAIT_CNT;
                    state     <= (WAIT_CNT == 4'd0) ? S_RESP : S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= S_RESP;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Gating on rstn drops a store whose commit edge coincides with reset.
    always_ff @(posedge clk) begin
        if (rstn && commit && op_we && !fault) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[op_addr[AW+1:2]][8*i +: 8] <= wd[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_dm_resp.sv
// Self-checking bench for dm_resp: directed load/store sequence, randomized
// accesses against a byte-array reference, and handshake timing patterns.
module tb_dm_resp;
    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  ls = 4'b0010;
    int          sel = 1;
    logic        rdy;
    logic        er;
    logic [31:0] rd;

    int checks = 0;
    int failures = 0;

    logic [7:0] ref_mem [0:4095];

    dm_resp_if b0 ();
    dm_resp_if b1 ();
    dm_resp_if b3 ();

    assign b0.req = req && (sel == 0);
    assign b1.req = req && (sel == 1);
    assign b3.req = req && (sel == 3);
    assign b0.we = we;       assign b1.we = we;       assign b3.we = we;
    assign b0.addr = addr;   assign b1.addr = addr;   assign b3.addr = addr;
    assign b0.wdata = wdata; assign b1.wdata = wdata; assign b3.wdata = wdata;
    assign b0.ls = ls;       assign b1.ls = ls;       assign b3.ls = ls;

    dm_resp #(.AW(10), .WAIT(0)) dut0 (.clk(clk), .rstn(rstn), .bus(b0));
    dm_resp #(.AW(10), .WAIT(1)) dut1 (.clk(clk), .rstn(rstn), .bus(b1));
    dm_resp #(.AW(10), .WAIT(3)) dut3 (.clk(clk), .rstn(rstn), .bus(b3));

    always #5 clk = ~clk;

    always_comb begin
        case (sel)
            0:       begin rdy = b0.ready; er = b0.err; rd = b0.rdata; end
            3:       begin rdy = b3.ready; er = b3.err; rd = b3.rdata; end
            default: begin rdy = b1.ready; er = b1.err; rd = b1.rdata; end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed memory, access legal iff naturally aligned and in range.
    task automatic model(input logic mwe, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] l, output logic [31:0] ex_rd, output logic ex_err);
        int n;
        logic [31:0] v;
        n = 1 << l[1:0];
        ex_err = (l[1:0] == 2'd3) || ((a % 32'(n)) != 0) || (a >= 32'd4096);
        ex_rd = '0;
        if (!ex_err) begin
            if (mwe) begin
                for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = d[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8*i));
                if (!l[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
                ex_rd = v;
            end
        end
    endtask

    task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] l, output logic [31:0] ord,
                             output logic oerr, output int lat);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; ls = l;
        @(posedge clk);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            req = 1'b0;
            if (rdy) begin
                lat = k;
                break;
            end
        end
        ord = rd;
        oerr = er;
    endtask

    // Access on the WAIT=1 instance, checked against the given expectations.
    task automatic acc(input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] l,
                       input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] got_rd;
        logic        got_err;
        int          lat;
        do_access(w, a, d, l, got_rd, got_err, lat);
        chk({tag, "_latency"}, 32'(lat), 32'd1);
        chk({tag, "_err"}, 32'(got_err), 32'(exp_err));
        chk({tag, "_rdata"}, got_rd, exp_rd);
    endtask

    task automatic dacc(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] l,
                        input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] m_rd;
        logic        m_err;
        model(w, a, d, l, m_rd, m_err);
        acc(tag, w, a, d, l, exp_rd, exp_err);
    endtask

    // Requests are accepted only when the responder is free; each acceptance
    // yields ready WAIT cycles later and the responder is busy for WAIT+2 cycles.
    function automatic logic [31:0] exp_ready(input int w, input logic [31:0] pat);
        int free_at;
        logic [31:0] e;
        free_at = 0;
        e = '0;
        for (int j = 0; j < 32; j++) begin
            if (pat[j] && j >= free_at) begin
                if (j + w < 32) e[j + w] = 1'b1;
                free_at = j + w + 2;
            end
        end
        return e;
    endfunction

    task automatic run_pat(input int w, input logic [31:0] pat, input string tag);
        logic [31:0] got;
        got = '0;
        req = 1'b0; we = 1'b0; addr = '0; ls = 4'b0010;
        sel = w;
        repeat (6) @(negedge clk);
        for (int j = 0; j < 28; j++) begin
            @(negedge clk);
            if (j > 0) got[j-1] = rdy;
            req = pat[j];
        end
        @(negedge clk);
        got[27] = rdy;
        req = 1'b0;
        chk(tag, got, exp_ready(w, pat));
        chk({tag, "_single"}, got & (got >> 1), 32'd0);
    endtask

    initial begin
        logic [31:0] m_rd;
        logic        m_err;
        logic        rw;
        logic [31:0] ra;
        logic [31:0] rdat;
        logic [3:0]  rl;

        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;

        #2 rstn = 1'b0;
        #1;
        chk("rst_ready0", 32'(b0.ready), 32'd0);
        chk("rst_ready1", 32'(b1.ready), 32'd0);
        chk("rst_ready3", 32'(b3.ready), 32'd0);
        chk("rst_err1", 32'(b1.err), 32'd0);
        chk("rst_rdata1", b1.rdata, 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Clear the low region so every later load reads defined data.
        for (int i = 0; i < 32; i++) begin
            model(1'b1, 32'(4*i), 32'd0, 4'b0010, m_rd, m_err);
            acc("init", 1'b1, 32'(4*i), 32'd0, 4'b0010, 32'd0, 1'b0);
        end

        dacc("sw_20",   1'b1, 32'h20, 32'hDEADBEEF, 4'b0010, 32'h0, 1'b0);
        dacc("lw_20",   1'b0, 32'h20, 32'h0,        4'b0010, 32'hDEADBEEF, 1'b0);
        dacc("lb_23",   1'b0, 32'h23, 32'h0,        4'b0000, 32'hFFFFFFDE, 1'b0);
        dacc("lbu_23",  1'b0, 32'h23, 32'h0,        4'b0100, 32'h000000DE, 1'b0);
        dacc("lh_20",   1'b0, 32'h20, 32'h0,        4'b0001, 32'hFFFFBEEF, 1'b0);
        dacc("lhu_22",  1'b0, 32'h22, 32'h0,        4'b0101, 32'h0000DEAD, 1'b0);
        dacc("sb_21",   1'b1, 32'h21, 32'hFFFFFF55, 4'b0000, 32'h0, 1'b0);
        dacc("lw_20b",  1'b0, 32'h20, 32'h0,        4'b0010, 32'hDEAD55EF, 1'b0);
        dacc("lw_22",   1'b0, 32'h22, 32'h0,        4'b0010, 32'h0, 1'b1);
        dacc("sh_21",   1'b1, 32'h21, 32'h0000AAAA, 4'b0001, 32'h0, 1'b1);
        dacc("lw_1000", 1'b0, 32'h1000, 32'h0,      4'b0010, 32'h0, 1'b1);
        dacc("size11",  1'b0, 32'h20, 32'h0,        4'b0011, 32'h0, 1'b1);
        dacc("lw_20c",  1'b0, 32'h20, 32'h0,        4'b0010, 32'hDEAD55EF, 1'b0);

        // Store aborted by reset while in WAIT must never reach the RAM.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h12345678; ls = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        rstn = 1'b0;
        #1;
        chk("midrst_ready", 32'(rdy), 32'd0);
        chk("midrst_err", 32'(er), 32'd0);
        chk("midrst_rdata", rd, 32'd0);
        @(negedge clk);
        chk("midrst_ready2", 32'(rdy), 32'd0);
        rstn = 1'b1;
        dacc("lw_10_after_rst", 1'b0, 32'h10, 32'h0, 4'b0010, 32'h0, 1'b0);

        for (int t = 0; t < 150; t++) begin
            rw = 1'(($urandom & 32'd1));
            rl = 4'($urandom_range(0, 15));
            rdat = $urandom;
            case ($urandom_range(0, 9))
                0:       ra = 32'h1000 + 32'($urandom_range(0, 63));
                1:       ra = $urandom | 32'h8000_0000;
                default: ra = 32'($urandom_range(0, 127));
            endcase
            model(rw, ra, rdat, rl, m_rd, m_err);
            acc("rnd", rw, ra, rdat, rl, m_rd, m_err);
        end

        run_pat(0, 32'h0000_03FF, "hold10_w0");
        run_pat(3, 32'h0000_03FF, "hold10_w3");
        run_pat(3, 32'h0000_0017, "busy_pulses_w3");
        run_pat(0, 32'h0000_0005, "busy_pulses_w0");
        for (int t = 0; t < 3; t++) begin
            run_pat(0, $urandom & 32'h000F_FFFF, "rndpat_w0");
            run_pat(1, $urandom & 32'h000F_FFFF, "rndpat_w1");
            run_pat(3, $urandom & 32'h000F_FFFF, "rndpat_w3");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
